// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider sequencing states and datapath constants.
package alu_pkg;

  localparam int WIDTH       = 32;
  localparam int DIV_LATENCY = 37;

  typedef enum logic [2:0] {
    IDLE,
    NEGA,
    NEGB,
    ITER,
    NEGQ,
    NEGR,
    DONE
  } div_state_e;

endpackage

// File: rtl/subtractor.sv
// Shared WIDTH-bit subtractor: r1 = r2 - r3, modulo 2^WIDTH.
module subtractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r1
);

  assign r1 = r2 - r3;

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned restoring divider that time-shares one subtractor
// for operand negation, the 32 division steps and the result sign fix-up.
module div_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] count_q;
  logic             signed_q;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rs;
  logic             carry;
  logic             ge;

  // The dividend lives in quo_q from acceptance onward, so it is negated in place
  // and becomes the initial shift register for the iterations without a copy.
  assign rs    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign carry = rem_q[WIDTH-1];
  assign ge    = carry | (rs >= div_q);

  always_comb begin
    sub_a = '0;
    sub_b = quo_q;
    case (state_q)
      NEGB:    sub_b = div_q;
      ITER: begin
        sub_a = rs;
        sub_b = div_q;
      end
      NEGR:    sub_b = rem_q;
      default: ;
    endcase
  end

  subtractor #(.WIDTH(WIDTH)) u_sub (
    .r2 (sub_a),
    .r3 (sub_b),
    .r1 (diff)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (divisor == '0) ? DONE : NEGA;
      NEGA:    state_d = NEGB;
      NEGB:    state_d = ITER;
      ITER:    if (count_q == CNT_W'(WIDTH - 1)) state_d = NEGQ;
      NEGQ:    state_d = NEGR;
      NEGR:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      count_q     <= '0;
      signed_q    <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              quo_q    <= dividend;
              div_q    <= divisor;
              signed_q <= is_signed;
              sign_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              sign_r   <= is_signed & dividend[WIDTH-1];
            end
          end
        end
        NEGA: if (signed_q && quo_q[WIDTH-1]) quo_q <= diff;
        NEGB: begin
          if (signed_q && div_q[WIDTH-1]) div_q <= diff;
          rem_q   <= '0;
          count_q <= '0;
        end
        ITER: begin
          rem_q   <= ge ? diff : rs;
          quo_q   <= {quo_q[WIDTH-2:0], ge};
          count_q <= count_q + 1'b1;
        end
        NEGQ: if (sign_q) quo_q <= diff;
        // Results are published on entry to DONE so they are valid alongside the pulse.
        NEGR: begin
          quotient    <= quo_q;
          remainder   <= sign_r ? diff : rem_q;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Randomised scoreboard bench for div_sequencer against a plain-arithmetic model.
module tb_div_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint x, y, qq, rr;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 1;
      return e;
    end
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    qq = x / y;
    rr = x % y;
    e.q = qq[31:0]; e.r = rr[31:0]; e.dbz = 1'b0; e.lat = DIV_LATENCY;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy || done) begin
      n++;
      if (n > 100) begin
        checks++; failures++;
        $display("FAIL wait_idle actual=busy required=idle");
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    sb_q.push_back(model(sgn, a, b));
    @(negedge clk);
    start     = 1'b0;
    is_signed = $urandom_range(0, 1);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Monitor: busy must stay high for exactly the expected latency before each done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst || !busy) busy_cnt = 0;
      else              busy_cnt++;
      if (!rst && done) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = sb_q.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
          check("latency", busy_cnt, e.lat);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b;
    int          n;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    issue(1'b0, 32'd100, 32'd7);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);
    issue(1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 32'd5, 32'd0);
    issue(1'b1, 32'd5, 32'd0);
    issue(1'b0, 32'd100, 32'd7);

    // Start with a zero divisor mid-operation must be ignored.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 32'd77; divisor = 32'd0;
    @(negedge clk);
    start = 1'b0;

    // Abort at cycle 12 of an operation; its result must never appear.
    issue(1'b1, 32'hFFFF_FB2E, 32'd17);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    issue(1'b0, 32'd9, 32'd3);

    repeat (40) begin
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 15);
        4:       b = 32'hFFFF_FFFF;
        5:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      issue($urandom_range(0, 1), a, b);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
